fixed_int26_6_div: RTL

- Signed 26.6 fixed-point divider, the divide counterpart of the team's 26.6 multiplier.
- Computes quotient = (A << 6) / B on 32-bit two's-complement 26.6 operands and returns a 32-bit 26.6 result.
- Uses a sequential restoring divider, one quotient bit per clock, to minimise area.
- Sits behind the same go/done pass-through and Ready/Stop operand/result channels as the multiplier, so the two can be swapped by the compiler's method binding.

---
 rtl/fixed_pkg.sv | 14 +
 rtl/fixed_udiv_step.sv | 15 +
 rtl/fixed_int26_6_div.sv | 79 +++++++
 3 files changed

// File: rtl/fixed_pkg.sv
// fixed_pkg: shared widths, FSM states and saturation constants for the 26.6 fixed-point units
package fixed_pkg;
  localparam int WIDTH = 32;
  localparam int FRAC_BITS = 6;
  localparam int N = WIDTH + FRAC_BITS;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);
  localparam logic [WIDTH-1:0] SAT_POS = 32'h7FFF_FFFF;
  localparam logic [WIDTH-1:0] SAT_NEG = 32'h8000_0000;
  typedef enum logic [1:0] {IDLE, ITERATE, FIX} state_t;
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction
endpackage

// File: rtl/fixed_udiv_step.sv
// fixed_udiv_step: one combinational restoring-division step (rem, dvd, dsr) -> (rem', dvd')
module fixed_udiv_step
  import fixed_pkg::*;
(
  input  logic [WIDTH-1:0] i_rem,
  input  logic [N-1:0]     i_dvd,
  input  logic [WIDTH-1:0] i_dsr,
  output logic [WIDTH-1:0] o_rem,
  output logic [N-1:0]     o_dvd
);
  logic [WIDTH:0] w_trial;
  assign w_trial = {i_rem, i_dvd[N-1]} - {1'b0, i_dsr};
  assign o_rem = w_trial[WIDTH] ? {i_rem[WIDTH-2:0], i_dvd[N-1]} : w_trial[WIDTH-1:0];
  assign o_dvd = {i_dvd[N-2:0], ~w_trial[WIDTH]};
endmodule

// File: rtl/fixed_int26_6_div.sv
// fixed_int26_6_div: signed 26.6 sequential divider, (A<<6)/B, Ready/Stop operand and result channels
module fixed_int26_6_div
  import fixed_pkg::*;
(
  input  logic               clk,
  input  logic               srstn,
  input  logic               goValid,
  output logic               goStop,
  output logic               doneValid,
  input  logic               doneStop,
  input  logic               operandsReady,
  input  logic [2*WIDTH-1:0] operandsData,
  output logic               operandsStop,
  output logic               resultReady,
  output logic [WIDTH-1:0]   resultData,
  input  logic               resultStop
);
  state_t             r_state, w_state_nx;
  logic [2*WIDTH-1:0] r_op;
  logic               r_op_valid, r_sign_q, r_sign_a, r_div0, r_result_ready;
  logic [WIDTH-1:0]   r_rem, r_dsr, r_result, w_a, w_b, w_rem_nx, w_q;
  logic [N-1:0]       r_dvd, w_dvd_nx;
  logic [CW-1:0]      r_cnt;
  logic               w_load, w_write;
  assign goStop = doneStop;
  assign doneValid = goValid;
  assign w_a = r_op[WIDTH-1:0];
  assign w_b = r_op[2*WIDTH-1:WIDTH];
  assign operandsStop = r_op_valid & (r_state != IDLE);
  assign resultReady = r_result_ready;
  assign resultData = r_result;
  assign w_load = (r_state == IDLE) & r_op_valid;
  assign w_write = (r_state == FIX) & ~r_result_ready;
  assign w_q = r_div0 ? (r_sign_a ? SAT_NEG : SAT_POS)
                      : (r_sign_q ? -r_dvd[WIDTH-1:0] : r_dvd[WIDTH-1:0]);
  fixed_udiv_step u_step (
    .i_rem(r_rem),
    .i_dvd(r_dvd),
    .i_dsr(r_dsr),
    .o_rem(w_rem_nx),
    .o_dvd(w_dvd_nx)
  );
  always_comb begin
    w_state_nx = r_state;
    if (w_load) w_state_nx = ITERATE;
    else if (r_state == ITERATE && r_cnt == '0) w_state_nx = FIX;
    else if (w_write) w_state_nx = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!srstn) begin
      r_state <= IDLE;
      r_op_valid <= 1'b0;
      r_result_ready <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_state <= w_state_nx;
      if (!operandsStop) r_op_valid <= operandsReady;
      if (w_load) r_cnt <= CNT_INIT;
      else if (r_state == ITERATE && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      if (w_write) r_result_ready <= 1'b1;
      else if (r_result_ready && !resultStop) r_result_ready <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!operandsStop) r_op <= operandsData;
    if (w_load) begin
      r_sign_q <= w_a[WIDTH-1] ^ w_b[WIDTH-1];
      r_sign_a <= w_a[WIDTH-1];
      r_div0 <= (w_b == '0);
      r_rem <= '0;
      r_dvd <= {abs_val(w_a), {FRAC_BITS{1'b0}}};
      r_dsr <= abs_val(w_b);
    end else if (r_state == ITERATE) begin
      r_rem <= w_rem_nx;
      r_dvd <= w_dvd_nx;
    end
    if (w_write) r_result <= w_q;
  end
endmodule
